rect_hit_scanner: RTL and testbench
===================================

# rect_hit_scanner

Sequential point-in-rectangle hit tester for the rectangle list held in graphics memory. The block accepts one query point, reads up to RECT_COUNT rectangles through a synchronous-read port, and tests each one with half-open signed bounds. It returns the index of the first or last hit rectangle and a hit count. Sprite picking, collision checks and input-to-object mapping use it without CPU iteration.

## Interface
- COORD_WIDTH, 16, width of all signed coordinates
- RECT_COUNT, 64, maximum rectangles scanned per query
- INDEX_WIDTH, $clog2(RECT_COUNT), width of rectangle index/address
- clk  in  1  single clock; everything is posedge clk
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  query request
- req_ready  out  1  high only in IDLE
- req_x, req_y  in  COORD_WIDTH  query point, signed
- req_count  in  INDEX_WIDTH+1  rectangles to scan, 0..RECT_COUNT; values above RECT_COUNT clamp to RECT_COUNT
- req_last_wins  in  1  1 = report highest hit index (full scan), 0 = report lowest hit index (early stop)
- rect_rd  out  1  memory read strobe
- rect_addr  out  INDEX_WIDTH  rectangle index being read
- rect_left, rect_top, rect_right, rect_bottom  in  COORD_WIDTH each  rectangle data, valid the cycle after rect_rd
- res_valid  out  1  result available, held until accepted
- res_ready  in  1  result consumer ready
- res_hit  out  1  at least one rectangle contains the point
- res_index  out  INDEX_WIDTH  reported hit index; 0 when res_hit=0
- res_hits  out  INDEX_WIDTH+1  number of hits counted

## Operation
- Hit test is signed: left <= x < right and top <= y < bottom. A degenerate rectangle with right <= left or bottom <= top never hits.
- The block has four states: IDLE, SCAN, DRAIN, DONE.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready. On acceptance the block latches x, y, mode and the clamped count. With count=0 it goes directly to DONE with res_hit=0 and res_hits=0. Otherwise it goes to SCAN.
- SCAN: asserts rect_rd and issues addresses 0..count-1, one per cycle. The compare stage tests the data returned for the previous address. After the last address is issued, the block enters DRAIN for the final compare.
- Hit handling in last-wins mode: every hit overwrites res_index and increments res_hits.
- Hit handling in first-wins mode: the first hit sets res_index, sets res_hits=1, and moves the block to DONE. The one address already issued ahead is ignored.
- DONE: res_valid=1 and all result outputs are stable. When res_ready is high, the block returns to IDLE on the next edge.
- Reset values: res_valid=0, res_hit=0, res_index=0, res_hits=0, rect_rd=0, rect_addr=0; state goes to IDLE, so req_ready=1 the cycle after reset releases.
- Reset mid-scan or in DONE aborts immediately. The pending result is discarded and no res_valid pulse appears.
- req_valid is ignored outside IDLE.
- Changes to req_* after acceptance have no effect on the query in progress.

## Timing
- Cycle 0 is the acceptance edge.
- rect_rd is high for cycles 1..N, with rect_addr = cycle-1.
- Data for address k is compared at cycle k+2.
- Last-wins mode, or first-wins with no hit: res_valid rises at cycle N+2. Latency is N+2.
- First-wins hit at index k: res_valid rises at cycle k+3. rect_rd is low from cycle k+3.
- N=0: res_valid rises at cycle 1.
- A result accepted at cycle t (res_valid && res_ready) gives req_ready=1 at cycle t+1. Back-to-back throughput is therefore N+3 cycles per query.
- res_index and res_hits do not change while res_valid=1.
- No combinational path exists from req_* or rect_* to any output.

## Structure
- Package rect_pkg holds:
  - the rect_t struct (left, top, right, bottom; COORD_WIDTH each),
  - the state enum (IDLE, SCAN, DRAIN, DONE),
  - default COORD_WIDTH and RECT_COUNT constants, shared with the renderer.
- Sub-module rect_contains is a combinational signed half-open point-in-rect test, instantiated once in the compare stage. It is reusable by the rasteriser.
- The top level holds the FSM, address counter, compare-stage pipeline register (valid plus index), and result registers.

## Test plan
- Last-wins overlap: rect0=(0,0,10,10), rect1=(5,5,20,20), rect2=(100,100,110,110), N=3, point (7,7) -> res_hit=1, res_index=1, res_hits=2, res_valid at cycle 5.
- First-wins early stop: same rectangles and point, req_last_wins=0 -> res_index=0, res_hits=1, res_valid at cycle 3, rect_rd low from cycle 3.
- Edge and sign rules: rect=(-10,-10,0,0). Point (-10,-10) -> hit. Point (0,-5) -> miss. Point (-1,-1) -> hit. Degenerate rect (5,5,5,9), point (5,6) -> miss.
- Count boundaries: N=0 -> res_valid at cycle 1, res_hit=0, res_index=0, no rect_rd. req_count=RECT_COUNT+5 -> exactly RECT_COUNT reads, addresses 0..RECT_COUNT-1.
- Backpressure: hold res_ready=0 for 10 cycles -> results stable, req_ready=0, a new req_valid is ignored. Release -> req_ready=1 next cycle.
- Reset mid-scan: reset_n low at cycle 3 of an N=8 scan -> next cycle rect_rd=0, res_valid=0, req_ready=1 after release. A fresh query then completes correctly.

Source files
------------

// File: rtl/rect_pkg.sv
// rtl/rect_pkg.sv - shared rectangle types, scanner states and default sizes
package rect_pkg;

  localparam int DEFAULT_COORD_WIDTH = 16;
  localparam int DEFAULT_RECT_COUNT  = 64;

  typedef struct packed {
    logic signed [DEFAULT_COORD_WIDTH-1:0] left;
    logic signed [DEFAULT_COORD_WIDTH-1:0] top;
    logic signed [DEFAULT_COORD_WIDTH-1:0] right;
    logic signed [DEFAULT_COORD_WIDTH-1:0] bottom;
  } rect_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/rect_contains.sv
// rtl/rect_contains.sv - combinational signed half-open point-in-rectangle test
module rect_contains
  import rect_pkg::*;
#(
  parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH
) (
  input  logic signed [COORD_WIDTH-1:0] x,
  input  logic signed [COORD_WIDTH-1:0] y,
  input  logic signed [COORD_WIDTH-1:0] left,
  input  logic signed [COORD_WIDTH-1:0] top,
  input  logic signed [COORD_WIDTH-1:0] right,
  input  logic signed [COORD_WIDTH-1:0] bottom,
  output logic                          hit
);

  // Degenerate rectangles fall out naturally: no x satisfies left <= x < right when right <= left.
  assign hit = (x >= left) && (x < right) && (y >= top) && (y < bottom);

endmodule

// File: rtl/rect_hit_scanner.sv
// rtl/rect_hit_scanner.sv - sequential point-in-rectangle scan over a synchronous-read rectangle list
module rect_hit_scanner
  import rect_pkg::*;
#(
  parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH,
  parameter int RECT_COUNT  = DEFAULT_RECT_COUNT,
  parameter int INDEX_WIDTH = $clog2(RECT_COUNT)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic signed [COORD_WIDTH-1:0] req_x,
  input  logic signed [COORD_WIDTH-1:0] req_y,
  input  logic [INDEX_WIDTH:0]          req_count,
  input  logic                          req_last_wins,
  output logic                          rect_rd,
  output logic [INDEX_WIDTH-1:0]        rect_addr,
  input  logic signed [COORD_WIDTH-1:0] rect_left,
  input  logic signed [COORD_WIDTH-1:0] rect_top,
  input  logic signed [COORD_WIDTH-1:0] rect_right,
  input  logic signed [COORD_WIDTH-1:0] rect_bottom,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic                          res_hit,
  output logic [INDEX_WIDTH-1:0]        res_index,
  output logic [INDEX_WIDTH:0]          res_hits
);

  localparam logic [INDEX_WIDTH:0] MAX_COUNT = (INDEX_WIDTH+1)'(RECT_COUNT);

  scan_state_t                   state;
  logic signed [COORD_WIDTH-1:0] query_x;
  logic signed [COORD_WIDTH-1:0] query_y;
  logic                          last_wins;
  logic [INDEX_WIDTH-1:0]        last_addr;
  logic                          cmp_valid;
  logic [INDEX_WIDTH-1:0]        cmp_index;
  logic                          cmp_hit;
  logic [INDEX_WIDTH:0]          count_clamped;

  assign count_clamped = (req_count > MAX_COUNT) ? MAX_COUNT : req_count;
  assign req_ready     = (state == IDLE);

  rect_contains #(
    .COORD_WIDTH(COORD_WIDTH)
  ) u_contains (
    .x     (query_x),
    .y     (query_y),
    .left  (rect_left),
    .top   (rect_top),
    .right (rect_right),
    .bottom(rect_bottom),
    .hit   (cmp_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      query_x   <= '0;
      query_y   <= '0;
      last_wins <= 1'b0;
      last_addr <= '0;
      cmp_valid <= 1'b0;
      cmp_index <= '0;
      rect_rd   <= 1'b0;
      rect_addr <= '0;
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_index <= '0;
      res_hits  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            query_x   <= req_x;
            query_y   <= req_y;
            last_wins <= req_last_wins;
            last_addr <= INDEX_WIDTH'(count_clamped - 1'b1);
            rect_addr <= '0;
            cmp_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_index <= '0;
            res_hits  <= '0;
            if (count_clamped == '0) begin
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rect_rd <= 1'b1;
              state   <= SCAN;
            end
          end
        end
        SCAN: begin
          cmp_valid <= 1'b1;
          cmp_index <= rect_addr;
          if (rect_addr == last_addr) begin
            rect_rd <= 1'b0;
            state   <= DRAIN;
          end else begin
            rect_addr <= rect_addr + 1'b1;
          end
          // A first-wins hit overrides the address stepping above; the read already in flight is dropped.
          if (cmp_valid && cmp_hit) begin
            res_hit   <= 1'b1;
            res_index <= cmp_index;
            if (last_wins) begin
              res_hits <= res_hits + 1'b1;
            end else begin
              res_hits  <= (INDEX_WIDTH+1)'(1);
              rect_rd   <= 1'b0;
              cmp_valid <= 1'b0;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DRAIN: begin
          cmp_valid <= 1'b0;
          if (cmp_valid && cmp_hit) begin
            res_hit   <= 1'b1;
            res_index <= cmp_index;
            res_hits  <= last_wins ? res_hits + 1'b1 : (INDEX_WIDTH+1)'(1);
          end
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_hit_scanner.sv
// tb/tb_rect_hit_scanner.sv - scoreboard bench for rect_hit_scanner against a loop-based hit model
module tb_rect_hit_scanner;

  localparam int CW = 16;
  localparam int RC = 64;
  localparam int IW = 6;

  typedef struct {
    bit hit;
    int index;
    int hits;
    int lat;
    int reads;
    int accept;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 req_valid;
  logic                 req_ready;
  logic signed [CW-1:0] req_x;
  logic signed [CW-1:0] req_y;
  logic [IW:0]          req_count;
  logic                 req_last_wins;
  logic                 rect_rd;
  logic [IW-1:0]        rect_addr;
  logic signed [CW-1:0] rect_left;
  logic signed [CW-1:0] rect_top;
  logic signed [CW-1:0] rect_right;
  logic signed [CW-1:0] rect_bottom;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_hit;
  logic [IW-1:0]        res_index;
  logic [IW:0]          res_hits;

  logic signed [CW-1:0] mem_l [RC];
  logic signed [CW-1:0] mem_t [RC];
  logic signed [CW-1:0] mem_r [RC];
  logic signed [CW-1:0] mem_b [RC];

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   read_count = 0;
  bit   prev_valid = 0;
  bit   rr_random = 0;
  bit   rr_level = 1;
  bit   cap_hit;
  int   cap_index;
  int   cap_hits;

  rect_hit_scanner #(.COORD_WIDTH(CW), .RECT_COUNT(RC), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_count(req_count), .req_last_wins(req_last_wins),
    .rect_rd(rect_rd), .rect_addr(rect_addr),
    .rect_left(rect_left), .rect_top(rect_top), .rect_right(rect_right), .rect_bottom(rect_bottom),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_index(res_index), .res_hits(res_hits)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read rectangle memory: data follows the strobe by one cycle.
  always @(posedge clk) begin
    if (rect_rd) begin
      rect_left   <= mem_l[rect_addr];
      rect_top    <= mem_t[rect_addr];
      rect_right  <= mem_r[rect_addr];
      rect_bottom <= mem_b[rect_addr];
    end
  end

  always @(negedge clk) res_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_level;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int cnt, input bit lw);
    exp_t e;
    int n;
    n = (cnt > RC) ? RC : cnt;
    e.hit = 0; e.index = 0; e.hits = 0; e.accept = 0;
    e.lat = (n == 0) ? 1 : n + 2;
    e.reads = n;
    for (int i = 0; i < n; i++) begin
      int l, t, r, b;
      l = mem_l[i]; t = mem_t[i]; r = mem_r[i]; b = mem_b[i];
      if (l <= x && x < r && t <= y && y < b) begin
        e.hit = 1;
        e.index = i;
        e.hits++;
        if (!lw) begin
          e.hits = 1;
          e.lat = i + 3;
          e.reads = (i + 2 < n) ? i + 2 : n;
          return e;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_valid = 0;
      read_count = 0;
    end else begin
      if (rect_rd) begin
        check_eq("rd_addr", int'(rect_addr), read_count);
        check_eq("rd_while_valid", int'(res_valid), 0);
        read_count++;
      end
      if (res_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("res_hit", int'(res_hit), int'(e.hit));
          check_eq("res_index", int'(res_index), e.index);
          check_eq("res_hits", int'(res_hits), e.hits);
          check_eq("latency", cyc - e.accept + 1, e.lat);
          check_eq("read_count", read_count, e.reads);
        end
        cap_hit = res_hit;
        cap_index = res_index;
        cap_hits = res_hits;
        read_count = 0;
      end else if (res_valid) begin
        check_eq("stable_hit", int'(res_hit), int'(cap_hit));
        check_eq("stable_index", int'(res_index), cap_index);
        check_eq("stable_hits", int'(res_hits), cap_hits);
      end
      prev_valid = res_valid;
    end
  end

  task automatic set_rect(input int i, input int l, input int t, input int r, input int b);
    mem_l[i] = 16'(l); mem_t[i] = 16'(t); mem_r[i] = 16'(r); mem_b[i] = 16'(b);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < RC; i++) begin
      int l, t;
      if ($urandom_range(0, 7) == 0) begin
        mem_l[i] = 16'($urandom); mem_t[i] = 16'($urandom);
        mem_r[i] = 16'($urandom); mem_b[i] = 16'($urandom);
      end else begin
        l = int'($urandom_range(0, 80)) - 40;
        t = int'($urandom_range(0, 80)) - 40;
        set_rect(i, l, t, l + int'($urandom_range(0, 35)) - 5, t + int'($urandom_range(0, 35)) - 5);
      end
    end
  endtask

  task automatic issue(input int x, input int y, input int cnt, input bit lw);
    exp_t e;
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check_eq("issue_timeout", 0, 1);
      return;
    end
    e = model(x, y, cnt, lw);
    e.accept = cyc + 1;
    sb.push_back(e);
    req_x = 16'(x); req_y = 16'(y); req_count = 7'(cnt); req_last_wins = lw;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_x = 16'($urandom); req_y = 16'($urandom); req_count = 7'($urandom); req_last_wins = ~lw;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check_eq("idle_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic rand_point(output int x, output int y);
    logic signed [CW-1:0] t;
    if ($urandom_range(0, 7) == 0) begin
      t = 16'($urandom); x = t;
      t = 16'($urandom); y = t;
    end else begin
      x = int'($urandom_range(0, 90)) - 45;
      y = int'($urandom_range(0, 90)) - 45;
    end
  endtask

  initial begin
    #500000;
    check_eq("watchdog", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int x, y, e_acc;
    bit ok;
    reset_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_count = '0; req_last_wins = 1'b0;
    for (int i = 0; i < RC; i++) set_rect(i, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_res_valid", int'(res_valid), 0);
    check_eq("rst_res_hit", int'(res_hit), 0);
    check_eq("rst_res_index", int'(res_index), 0);
    check_eq("rst_res_hits", int'(res_hits), 0);
    check_eq("rst_rect_rd", int'(rect_rd), 0);
    check_eq("rst_rect_addr", int'(rect_addr), 0);
    check_eq("rst_req_ready", int'(req_ready), 1);

    // Overlap, both modes
    set_rect(0, 0, 0, 10, 10); set_rect(1, 5, 5, 20, 20); set_rect(2, 100, 100, 110, 110);
    issue(7, 7, 3, 1); wait_idle();
    issue(7, 7, 3, 0); wait_idle();

    // Edge, sign and degenerate rules
    set_rect(0, -10, -10, 0, 0);
    issue(-10, -10, 1, 1); issue(0, -5, 1, 1); issue(-1, -1, 1, 0); wait_idle();
    set_rect(0, 5, 5, 5, 9);
    issue(5, 6, 1, 1); wait_idle();

    // Count boundaries
    issue(0, 0, 0, 1); issue(0, 0, 0, 0); wait_idle();
    rand_mem();
    issue(3, 3, RC + 5, 1); wait_idle();
    issue(-3, 4, RC, 0); wait_idle();

    // Backpressure with an ignored request
    rr_level = 1'b0;
    issue(2, 2, 10, 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1; break; end
    end
    check_eq("bp_result_seen", int'(ok), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_req_ready", int'(req_ready), 0);
      check_eq("bp_res_valid", int'(res_valid), 1);
      req_count = 7'd5;
      req_valid = (i >= 2 && i < 8);
    end
    req_valid = 1'b0;
    rr_level = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!res_valid) break;
    end
    check_eq("bp_release_valid", int'(res_valid), 0);
    check_eq("bp_release_ready", int'(req_ready), 1);
    wait_idle();

    // Reset in the middle of an N=8 scan
    issue(1, 1, 8, 1);
    e_acc = cyc;
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_scan_edge", cyc - e_acc, 3);
    check_eq("rst_scan_rect_rd", int'(rect_rd), 0);
    check_eq("rst_scan_res_valid", int'(res_valid), 0);
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_scan_req_ready", int'(req_ready), 1);
    issue(7, 7, 12, 1); wait_idle();

    // Randomized queries with random result backpressure
    rr_random = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        rand_mem();
      end
      rand_point(x, y);
      issue(x, y, int'($urandom_range(0, 70)), 1'($urandom));
    end
    wait_idle();
    rr_random = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("final_queue_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
